// File: rtl/master_bridge_r_channel_driver.sv
// R-channel driver for the AXI-PCIe master bridge.
// Pops one data beat plus its info word from the R-channel FIFO pair, holds
// them in a 2-entry (head + skid) buffer and drives the AXI R channel with
// full-throughput valid/ready. A 9-bit beat counter flags bursts that run
// past MAX_BURST_LEN beats without RLAST (sticky until reset).
// Optional: define MASTER_BRIDGE_R_PERF_CNT_EN to add o_beat_cnt/o_burst_cnt.
module master_bridge_r_channel_driver #(
    parameter int DW              = 32,
    parameter int BEAT_SIZE       = 32*DW,
    parameter int R_CH_INFO_WIDTH = 56,
    parameter int ID_WIDTH        = 10,
    parameter int MAX_BURST_LEN   = 256
) (
    input  logic                       i_clk,
    input  logic                       i_n_rst,
    input  logic                       i_r_empty_flag,
    input  logic [BEAT_SIZE-1:0]       i_r_data,
    input  logic [R_CH_INFO_WIDTH-1:0] i_r_info,
    output logic                       o_r_data_inc,
    output logic                       o_r_info_inc,
    output logic                       o_rvalid,
    input  logic                       i_rready,
    output logic [BEAT_SIZE-1:0]       o_rdata,
    output logic [ID_WIDTH-1:0]        o_rid,
    output logic [1:0]                 o_rresp,
    output logic                       o_rlast,
`ifdef MASTER_BRIDGE_R_PERF_CNT_EN
    output logic [31:0]                o_beat_cnt,
    output logic [31:0]                o_burst_cnt,
`endif
    output logic                       o_err_len_overflow
);

    localparam logic [8:0] LEN_LAST = 9'(MAX_BURST_LEN - 1);

    logic                 run;
    logic [1:0]           occ;
    logic                 pop;
    logic                 drain;
    logic [8:0]           beat_idx;

    logic [BEAT_SIZE-1:0] skid_data;
    logic [ID_WIDTH-1:0]  skid_id;
    logic [1:0]           skid_resp;
    logic                 skid_last;

    logic [1:0]           in_resp;
    logic                 in_last;
    logic [ID_WIDTH-1:0]  in_id;
    logic                 unused_info;

    assign in_resp     = i_r_info[1:0];
    assign in_last     = i_r_info[2];
    assign in_id       = i_r_info[2+ID_WIDTH:3];
    assign unused_info = ^i_r_info[R_CH_INFO_WIDTH-1:3+ID_WIDTH];

    // Pop depends only on registered state and the FIFO flag, never on RREADY.
    // 'run' keeps the pop strobes low while reset is held and for the
    // release edge, so nothing is popped into a buffer being cleared.
    assign pop          = run && !i_r_empty_flag && (occ != 2'd2);
    assign o_r_data_inc = pop;
    assign o_r_info_inc = pop;
    assign o_rvalid     = (occ != 2'd0);
    assign drain        = o_rvalid && i_rready;

    // Pop enable: goes high the first clock after reset release.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) run <= 1'b0;
        else          run <= 1'b1;
    end

    // Buffer occupancy: occ + pop - drain.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            occ <= 2'd0;
        end else begin
            case ({pop, drain})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Head/skid loading; head fields hold while stalled.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            o_rdata   <= '0;
            o_rid     <= '0;
            o_rresp   <= '0;
            o_rlast   <= 1'b0;
            skid_data <= '0;
            skid_id   <= '0;
            skid_resp <= '0;
            skid_last <= 1'b0;
        end else begin
            if (pop && ((occ == 2'd0) || ((occ == 2'd1) && drain))) begin
                o_rdata <= i_r_data;
                o_rid   <= in_id;
                o_rresp <= in_resp;
                o_rlast <= in_last;
            end else if ((occ == 2'd2) && drain) begin
                o_rdata <= skid_data;
                o_rid   <= skid_id;
                o_rresp <= skid_resp;
                o_rlast <= skid_last;
            end
            if (pop && (occ == 2'd1) && !drain) begin
                skid_data <= i_r_data;
                skid_id   <= in_id;
                skid_resp <= in_resp;
                skid_last <= in_last;
            end
        end
    end

    // Burst length tracking; a drain at index MAX_BURST_LEN-1 without RLAST
    // latches the overflow error and wraps the index.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            beat_idx           <= 9'd0;
            o_err_len_overflow <= 1'b0;
        end else if (drain) begin
            if (o_rlast) begin
                beat_idx <= 9'd0;
            end else if (beat_idx == LEN_LAST) begin
                beat_idx           <= 9'd0;
                o_err_len_overflow <= 1'b1;
            end else begin
                beat_idx <= beat_idx + 9'd1;
            end
        end
    end

`ifdef MASTER_BRIDGE_R_PERF_CNT_EN
    // Free-running beat and burst counters, wrapping at 2^32.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            o_beat_cnt  <= 32'd0;
            o_burst_cnt <= 32'd0;
        end else if (drain) begin
            o_beat_cnt <= o_beat_cnt + 32'd1;
            if (o_rlast) o_burst_cnt <= o_burst_cnt + 32'd1;
        end
    end
`endif

endmodule
